// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the WISC pipeline.
// Owns the PC register and the IF/ID pipeline register, applies hazard-unit
// stall/flush controls and ID-stage redirects, freezes fetch on HLT and
// keeps a saturating count of stalled cycles for performance debug.
module fetch_stage #(
    parameter int unsigned   ADDR_W      = 16,
    parameter int unsigned   INSTR_W     = 16,
    parameter logic [15:0]   RESET_PC    = 16'h0000,
    parameter logic [3:0]    HALT_OPCODE = 4'hF,
    parameter logic [15:0]   NOP_INSTR   = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_wen,
    input  logic               if_id_wen,
    input  logic               if_id_flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus2,
    output logic               if_id_valid,
    output logic               fetch_halted,
    output logic [15:0]        stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_if_id_instr;
    logic [ADDR_W-1:0]   r_if_id_pc_plus2;
    logic                r_if_id_valid;
    logic                r_fetch_halted;
    logic [15:0]         r_stall_cnt;

    logic [ADDR_W-1:0]   w_pc_plus2;
    logic                w_is_hlt;
    logic                w_stall;

    // Sequential-address and decode helpers for the current fetch
    always_comb begin
        w_pc_plus2 = r_pc + ADDR_W'(2);
        w_is_hlt   = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);
        w_stall    = (r_state == RUN) && !pc_wen && !branch_taken;
    end

    // PC and RUN/HALT state; a redirect beats stall and HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= ADDR_W'(RESET_PC);
            r_state        <= RUN;
            r_fetch_halted <= 1'b0;
        end else if (branch_taken) begin
            r_pc           <= branch_target;
            r_state        <= RUN;
            r_fetch_halted <= 1'b0;
        end else if (!pc_wen) begin
            r_pc <= r_pc;
        end else if (r_state == HALT) begin
            r_pc <= r_pc;
        end else if (w_is_hlt) begin
            // PC stays on the HLT word; the HLT itself still enters IF/ID this edge
            r_state        <= HALT;
            r_fetch_halted <= 1'b1;
        end else begin
            r_pc <= w_pc_plus2;
        end
    end

    // IF/ID pipeline register: flush, hold, bubble while halted, else capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id_instr    <= INSTR_W'(NOP_INSTR);
            r_if_id_pc_plus2 <= '0;
            r_if_id_valid    <= 1'b0;
        end else if (if_id_flush) begin
            r_if_id_instr <= INSTR_W'(NOP_INSTR);
            r_if_id_valid <= 1'b0;
        end else if (!if_id_wen) begin
            r_if_id_valid <= r_if_id_valid;
        end else if (r_state == HALT) begin
            r_if_id_instr <= INSTR_W'(NOP_INSTR);
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_instr    <= imem_data;
            r_if_id_pc_plus2 <= w_pc_plus2;
            r_if_id_valid    <= 1'b1;
        end
    end

    // Saturating count of cycles the hazard unit stalled a running fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus2 = r_if_id_pc_plus2;
    assign if_id_valid    = r_if_id_valid;
    assign fetch_halted   = r_fetch_halted;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage with a queue-based
// scoreboard. The stimulus process pushes the hand-computed expected state
// for each edge; the monitor pops and compares just after that edge (or
// mid-cycle for the asynchronous reset checks).
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_wen;
    logic        if_id_wen;
    logic        if_id_flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        fetch_halted;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 0;
    event sample_req;

    fetch_stage #(
        .ADDR_W      (16),
        .INSTR_W     (16),
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF),
        .NOP_INSTR   (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_wen         (pc_wen),
        .if_id_wen      (if_id_wen),
        .if_id_flush    (if_id_flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .fetch_halted   (fetch_halted),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk or sample_req);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "pc",        pc,                    e.pc);
                cmp(e.name, "imem_addr", imem_addr,             e.pc);
                cmp(e.name, "instr",     if_id_instr,           e.instr);
                cmp(e.name, "pc_plus2",  if_id_pc_plus2,        e.pp2);
                cmp(e.name, "valid",     {15'd0, if_id_valid},  {15'd0, e.valid});
                cmp(e.name, "halted",    {15'd0, fetch_halted}, {15'd0, e.halted});
                cmp(e.name, "stall_cnt", stall_cnt,             e.cnt);
            end
        end
    end

    task automatic push(input string nm, input logic [15:0] e_pc, input logic [15:0] e_instr,
                        input logic [15:0] e_pp2, input logic e_valid, input logic e_halt,
                        input logic [15:0] e_cnt);
        exp_t e;
        e.name = nm; e.pc = e_pc; e.instr = e_instr; e.pp2 = e_pp2;
        e.valid = e_valid; e.halted = e_halt; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs (called at negedge), queue state expected after the edge
    task automatic step(input string nm, input logic pcw, input logic ifw, input logic fl,
                        input logic br, input logic [15:0] tgt, input logic [15:0] im,
                        input logic [15:0] e_pc, input logic [15:0] e_instr,
                        input logic [15:0] e_pp2, input logic e_valid, input logic e_halt,
                        input logic [15:0] e_cnt);
        pc_wen = pcw; if_id_wen = ifw; if_id_flush = fl;
        branch_taken = br; branch_target = tgt; imem_data = im;
        push(nm, e_pc, e_instr, e_pp2, e_valid, e_halt, e_cnt);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_wen = 1'b1; if_id_wen = 1'b1; if_id_flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; imem_data = 16'h1234;
        #2;
        push("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
        ->sample_req;
        @(negedge clk);
        rst_n = 1'b1;

        //    name      pcw ifw fl br tgt       imem      pc        instr     pp2      v  h  cnt
        step("run1",    1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 16'd0);
        step("run2",    1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0, 16'd0);
        step("run3",    1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd0);
        step("run4",    1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0008, 16'h1234, 16'h0008, 1, 0, 16'd0);
        step("brflush", 1,  1,  1, 1, 16'h0040, 16'h1234, 16'h0040, 16'h0000, 16'h0008, 0, 0, 16'd0);
        step("br10",    1,  1,  0, 1, 16'h0010, 16'h2222, 16'h0010, 16'h2222, 16'h0042, 1, 0, 16'd0);
        step("stall1",  0,  0,  0, 0, 16'h0000, 16'h3333, 16'h0010, 16'h2222, 16'h0042, 1, 0, 16'd1);
        step("stall2",  0,  0,  0, 0, 16'h0000, 16'h3333, 16'h0010, 16'h2222, 16'h0042, 1, 0, 16'd2);
        step("stall3",  0,  0,  0, 0, 16'h0000, 16'h3333, 16'h0010, 16'h2222, 16'h0042, 1, 0, 16'd3);
        step("resume",  1,  1,  0, 0, 16'h0000, 16'h3333, 16'h0012, 16'h3333, 16'h0012, 1, 0, 16'd3);
        step("br0c",    1,  1,  0, 1, 16'h000C, 16'h4444, 16'h000C, 16'h4444, 16'h0014, 1, 0, 16'd3);
        step("hlt",     1,  1,  0, 0, 16'h0000, 16'hF000, 16'h000C, 16'hF000, 16'h000E, 1, 1, 16'd3);
        step("halt1",   1,  1,  0, 0, 16'h0000, 16'hF000, 16'h000C, 16'h0000, 16'h000E, 0, 1, 16'd3);
        step("haltstl", 0,  1,  0, 0, 16'h0000, 16'hF000, 16'h000C, 16'h0000, 16'h000E, 0, 1, 16'd3);
        step("haltbr",  1,  1,  0, 1, 16'h0020, 16'hF000, 16'h0020, 16'h0000, 16'h000E, 0, 0, 16'd3);
        step("run20",   1,  1,  0, 0, 16'h0000, 16'h5555, 16'h0022, 16'h5555, 16'h0022, 1, 0, 16'd3);
        step("hltbr",   1,  1,  0, 1, 16'h0030, 16'hF000, 16'h0030, 16'hF000, 16'h0024, 1, 0, 16'd3);
        step("hltstl",  0,  0,  0, 0, 16'h0000, 16'hF000, 16'h0030, 16'hF000, 16'h0024, 1, 0, 16'd4);
        step("run30",   1,  1,  0, 0, 16'h0000, 16'h6666, 16'h0032, 16'h6666, 16'h0032, 1, 0, 16'd4);
        step("brfffe",  1,  1,  0, 1, 16'hFFFE, 16'h7777, 16'hFFFE, 16'h7777, 16'h0034, 1, 0, 16'd4);
        step("wrap",    1,  1,  0, 0, 16'h0000, 16'h8888, 16'h0000, 16'h8888, 16'h0000, 1, 0, 16'd4);
        step("after",   1,  1,  0, 0, 16'h0000, 16'h9999, 16'h0002, 16'h9999, 16'h0002, 1, 0, 16'd4);
        step("hlt2",    1,  1,  0, 0, 16'h0000, 16'hF000, 16'h0002, 16'hF000, 16'h0004, 1, 1, 16'd4);
        step("halt2",   1,  1,  0, 0, 16'h0000, 16'hF000, 16'h0002, 16'h0000, 16'h0004, 0, 1, 16'd4);

        // Asynchronous reset mid-cycle while halted with a non-zero stall count
        #1;
        push("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b0;
        ->sample_req;
        @(negedge clk);
        step("rsthold", 1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
        rst_n = 1'b1;
        step("rstrun",  1,  1,  0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 16'd0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
